serial_tx: RTL and testbench

Parallel-to-serial transmitter: accepts a DATA_W-bit word over a valid/ready handshake and drives it onto a single idle-high line as a start bit, the data bits LSB first, an optional even-parity bit, and a stop bit. Each bit lasts CLKS_PER_BIT clock cycles. It is the sending end of the team's serial link and sits between a parallel producer and the line that feeds the matching receiver.

---
 rtl/serial_tx.sv | 174 +++++++++++++++++
 tb/tb_serial_tx.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/serial_tx.sv
// serial_tx: parallel-to-serial transmitter with a valid/ready input handshake.
// Frame on an idle-high line: start bit (0), DATA_W data bits LSB first,
// optional even-parity bit, stop bit (1); every bit lasts CLKS_PER_BIT cycles.
// Optional feature macro: SERIAL_TX_PARITY_EN (adds the PARITY state and bit).
// The final stop-bit cycle is spent back in IDLE with o_done high, so a new
// handshake taken in the o_done cycle streams frames with no idle gap.
module serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_tx,
  output logic              o_busy,
  output logic              o_done
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int BW = $clog2(DATA_W) + 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef SERIAL_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;

  // Last cycle index of a normal bit.
  localparam logic [CW-1:0] CYC_LAST  = CW'(CLKS_PER_BIT - 1);
  // The stop bit's final cycle is the IDLE/o_done cycle, so STOP itself
  // only covers CLKS_PER_BIT-1 cycles.
  localparam logic [CW-1:0] STOP_LAST = CW'((CLKS_PER_BIT >= 2) ? CLKS_PER_BIT - 2 : 0);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
  // With one cycle per bit the whole stop bit is the IDLE/o_done cycle.
  localparam bit STOP_IN_IDLE = (CLKS_PER_BIT == 1);

  logic [2:0]        state;
  logic [CW-1:0]     cyc_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_nxt;
  logic              tx_q;
  logic              done_q;
  logic              cyc_end;
  logic              take;
  logic              shift_en;
`ifdef SERIAL_TX_PARITY_EN
  logic              parity;

  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction
`endif

  assign o_ready   = (state == IDLE);
  assign o_busy    = ~o_ready;
  assign o_tx      = tx_q;
  assign o_done    = done_q;

  assign cyc_end   = (cyc_cnt == CYC_LAST);
  assign take      = i_valid && o_ready && !i_rst;
  assign shift_en  = (state == DATA) && cyc_end && (bit_cnt != BIT_LAST);
  assign shreg_nxt = shreg >> 1;

  // Data path: capture the word on handshake, shift right at each data-bit end.
  always_ff @(posedge i_clk) begin
    if (take) begin
      shreg <= i_data;
`ifdef SERIAL_TX_PARITY_EN
      parity <= even_parity(i_data);
`endif
    end else if (shift_en) begin
      shreg <= shreg_nxt;
    end
  end

  // Control: frame state machine, bit/cycle counters, registered line and done pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      cyc_cnt <= '0;
      bit_cnt <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (i_valid) begin
            state   <= START;
            cyc_cnt <= '0;
            bit_cnt <= '0;
            tx_q    <= 1'b0;
          end
        end

        START: begin
          if (cyc_end) begin
            state   <= DATA;
            cyc_cnt <= '0;
            tx_q    <= shreg[0];
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end

        DATA: begin
          if (cyc_end) begin
            cyc_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
`ifdef SERIAL_TX_PARITY_EN
              state <= PARITY;
              tx_q  <= parity;
`else
              tx_q <= 1'b1;
              if (STOP_IN_IDLE) begin
                state  <= IDLE;
                done_q <= 1'b1;
              end else begin
                state <= STOP;
              end
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx_q    <= shreg_nxt[0];
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end

`ifdef SERIAL_TX_PARITY_EN
        PARITY: begin
          if (cyc_end) begin
            cyc_cnt <= '0;
            tx_q    <= 1'b1;
            if (STOP_IN_IDLE) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end else begin
              state <= STOP;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
`endif

        STOP: begin
          tx_q <= 1'b1;
          if (cyc_cnt == STOP_LAST) begin
            state   <= IDLE;
            cyc_cnt <= '0;
            done_q  <= 1'b1;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          cyc_cnt <= '0;
          bit_cnt <= '0;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx (DATA_W=8, CLKS_PER_BIT=4). Line bits are
// sampled at mid-bit; expected frames are built from the data word.
module tb_serial_tx;

  localparam int DW  = 8;
  localparam int CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int NB  = 11;
`else
  localparam int NB  = 10;
`endif
  localparam int FN  = NB * CPB;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          valid = 1'b0;
  logic [DW-1:0] data  = '0;
  logic          ready;
  logic          tx;
  logic          busy;
  logic          done;

  logic tx_log    [0:199];
  logic done_log  [0:199];
  logic ready_log [0:199];
  logic busy_log  [0:199];

  int vecs = 0;
  int errs = 0;

  serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_data  (data),
    .i_valid (valid),
    .o_ready (ready),
    .o_tx    (tx),
    .o_busy  (busy),
    .o_done  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected line bits, index 0 = start bit.
  function automatic logic [11:0] frame_bits(input logic [DW-1:0] d);
`ifdef SERIAL_TX_PARITY_EN
    return {1'b0, 1'b1, ^d, d, 1'b0};
`else
    return {2'b00, 1'b1, d, 1'b0};
`endif
  endfunction

  // Record outputs for cycles 1..n after a handshake edge (caller is in cycle 1).
  task automatic collect(input int n);
    for (int k = 1; k <= n; k++) begin
      tx_log[k]    = tx;
      done_log[k]  = done;
      ready_log[k] = ready;
      busy_log[k]  = busy;
      if (k < n) step();
    end
  endtask

  task automatic check_frame(input string tag, input logic [DW-1:0] d, input int base);
    logic [11:0] f;
    f = frame_bits(d);
    for (int b = 0; b < NB; b++)
      chk($sformatf("%s bit%0d", tag, b), 32'(tx_log[base + b*CPB + CPB/2 + 1]), 32'(f[b]));
  endtask

  function automatic int count_done(input int lo, input int hi);
    int c = 0;
    for (int k = lo; k <= hi; k++) if (done_log[k] === 1'b1) c++;
    return c;
  endfunction

  function automatic int count_ready(input int lo, input int hi);
    int c = 0;
    for (int k = lo; k <= hi; k++) if (ready_log[k] === 1'b1) c++;
    return c;
  endfunction

  initial begin
    int dcnt;
    int nrdy;

    // 1. reset held with valid high: no frame may start
    rst = 1'b1; valid = 1'b1; data = 8'h81;
    step(); step();
    chk("rst tx", 32'(tx), 32'd1);
    chk("rst ready", 32'(ready), 32'd1);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    rst = 1'b0; valid = 1'b0;
    step();
    chk("post-rst ready", 32'(ready), 32'd1);
    chk("post-rst tx", 32'(tx), 32'd1);

    // 2. single word 0xA5
    data = 8'hA5; valid = 1'b1;
    step();
    valid = 1'b0; data = 8'h00;
    collect(FN);
    check_frame("a5", 8'hA5, 0);
    chk("a5 busy c1", 32'(busy_log[1]), 32'd1);
    chk("a5 tx c1", 32'(tx_log[1]), 32'd0);
    chk("a5 done count", 32'(count_done(1, FN)), 32'd1);
    chk("a5 done last", 32'(done_log[FN]), 32'd1);
    chk("a5 ready last", 32'(ready_log[FN]), 32'd1);
    chk("a5 ready before last", 32'(ready_log[FN-1]), 32'd0);
    step();
    chk("a5 done drop", 32'(done), 32'd0);

    // 3. inputs change during the frame; no extra handshake
    data = 8'h3C; valid = 1'b1;
    step();
    data = 8'hFF;
    collect(FN);
    valid = 1'b0;
    check_frame("3c", 8'h3C, 0);
    chk("3c ready count", 32'(count_ready(1, FN)), 32'd1);
    chk("3c done count", 32'(count_done(1, FN)), 32'd1);
    step();
    chk("3c idle after", 32'(ready), 32'd1);
    chk("3c tx idle", 32'(tx), 32'd1);

    // 4. back-to-back 0x00 then 0xFF
    data = 8'h00; valid = 1'b1;
    step();
    data = 8'hFF;
    collect(2*FN);
    valid = 1'b0;
    check_frame("b2b0", 8'h00, 0);
    check_frame("b2b1", 8'hFF, FN);
    chk("b2b done count", 32'(count_done(1, 2*FN)), 32'd2);
    chk("b2b done1", 32'(done_log[FN]), 32'd1);
    chk("b2b done2", 32'(done_log[2*FN]), 32'd1);
    chk("b2b start2", 32'(tx_log[FN+1]), 32'd0);
    step();

    // 5. reset at cycle 18 of a frame
    data = 8'h55; valid = 1'b1;
    step();
    valid = 1'b0;
    for (int k = 1; k < 18; k++) step();
    chk("mid busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid-rst tx", 32'(tx), 32'd1);
    chk("mid-rst ready", 32'(ready), 32'd1);
    chk("mid-rst busy", 32'(busy), 32'd0);
    dcnt = 0; nrdy = 0;
    for (int k = 0; k < FN + 8; k++) begin
      if (done === 1'b1) dcnt++;
      if (ready !== 1'b1) nrdy++;
      step();
    end
    chk("mid-rst no done", 32'(dcnt), 32'd0);
    chk("mid-rst stays idle", 32'(nrdy), 32'd0);

`ifdef SERIAL_TX_PARITY_EN
    // 6. parity frames
    data = 8'h07; valid = 1'b1;
    step();
    valid = 1'b0;
    collect(FN);
    check_frame("p07", 8'h07, 0);
    chk("p07 parity", 32'(tx_log[9*CPB + 3]), 32'd1);
    chk("p07 done at 44", 32'(done_log[44]), 32'd1);
    chk("p07 done count", 32'(count_done(1, FN)), 32'd1);
    step();
    data = 8'h03; valid = 1'b1;
    step();
    valid = 1'b0;
    collect(FN);
    check_frame("p03", 8'h03, 0);
    chk("p03 parity", 32'(tx_log[9*CPB + 3]), 32'd0);
    step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
